sync_fifo_lvl: RTL and testbench

Parametrised synchronous FIFO for the 802.11a RX datapath, for example between the demapper, deinterleaver and Viterbi stages. It generalises the basic single-bit FIFO with configurable width and depth, a registered read port with a valid strobe, and an occupancy count. It also adds programmable almost-full/almost-empty flags, a synchronous flush, and full-with-read write acceptance. One clock domain.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fifo_lvl.sv | 118 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: sizing rules and accept-decode constants for the
// sync/async/multi-channel FIFO family.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // The count must represent 0..DEPTH inclusive, hence one bit above the address.
    function automatic int cnt_width_of(input int addr_width);
        return clog2(depth_of(addr_width) + 1);
    endfunction

    // A read in the same cycle frees the slot, so a write to a full FIFO is still taken.
    localparam logic WR_ON_FULL_WITH_RD = 1'b1;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous registered read, no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Same-address read and write return the old word, which is what a full FIFO needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Parametrised synchronous FIFO with level flags, flush and registered read port.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = cnt_width_of(ADDR_WIDTH)
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFlush,
    input  logic                  iW_EN,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iR_EN,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValid,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic [CNT_WIDTH-1:0]  oCount,
    input  logic [CNT_WIDTH-1:0]  iAFullThr,
    input  logic [CNT_WIDTH-1:0]  iAEmptyThr,
    output logic                  oAFull,
    output logic                  oAEmpty,
    output logic                  oOvf,
    output logic                  oUdf
);

    localparam int                   DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  has_data;
    logic [DATA_WIDTH-1:0] ram_q;

    assign oEmpty  = (count == '0);
    assign oFull   = (count == FULL_CNT);
    assign oCount  = count;
    assign oAFull  = (count >= iAFullThr);
    assign oAEmpty = (count <= iAEmptyThr);

    assign rd_acc = iR_EN & ~oEmpty;
    assign wr_acc = iW_EN & (~oFull | (WR_ON_FULL_WITH_RD & iR_EN));

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (iClk),
        .wr_en   (wr_acc & ~iFlush),
        .wr_addr (wr_ptr),
        .wr_data (iData),
        .rd_en   (rd_acc & ~iFlush),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // The RAM output register has no reset, so oData reads 0 until the first pop.
    assign oData = has_data ? ram_q : '0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            oValid   <= 1'b0;
            has_data <= 1'b0;
        end else if (iFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            oValid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                has_data <= 1'b1;
            end
            oValid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oOvf <= 1'b0;
            oUdf <= 1'b0;
        end else if (iFlush) begin
            oOvf <= 1'b0;
            oUdf <= 1'b0;
        end else begin
            if (iW_EN & ~wr_acc) begin
                oOvf <= 1'b1;
            end
            if (iR_EN & oEmpty) begin
                oUdf <= 1'b1;
            end
        end
    end
`else
    assign oOvf = 1'b0;
    assign oUdf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl (default 8x64 configuration).
// Expected error-flag values follow SYNC_FIFO_ERR_FLAGS_EN when it is defined.
module tb_sync_fifo_lvl;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       iClk;
    logic       iRst;
    logic       iFlush;
    logic       iW_EN;
    logic [7:0] iData;
    logic       iR_EN;
    logic [7:0] oData;
    logic       oValid;
    logic       oFull;
    logic       oEmpty;
    logic [6:0] oCount;
    logic [6:0] iAFullThr;
    logic [6:0] iAEmptyThr;
    logic       oAFull;
    logic       oAEmpty;
    logic       oOvf;
    logic       oUdf;

    int vectors;
    int miscompares;

    sync_fifo_lvl dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iFlush     (iFlush),
        .iW_EN      (iW_EN),
        .iData      (iData),
        .iR_EN      (iR_EN),
        .oData      (oData),
        .oValid     (oValid),
        .oFull      (oFull),
        .oEmpty     (oEmpty),
        .oCount     (oCount),
        .iAFullThr  (iAFullThr),
        .iAEmptyThr (iAEmptyThr),
        .oAFull     (oAFull),
        .oAEmpty    (oAEmpty),
        .oOvf       (oOvf),
        .oUdf       (oUdf)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
        iW_EN  = w;
        iData  = d;
        iR_EN  = r;
        iFlush = f;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        iRst        = 1'b1;
        iFlush      = 1'b0;
        iW_EN       = 1'b0;
        iR_EN       = 1'b0;
        iData       = 8'h00;
        iAFullThr   = 7'd48;
        iAEmptyThr  = 7'd8;
        repeat (2) @(posedge iClk);
        #1;
        checkOutput("rst_data",  32'(oData),  32'h0);
        checkOutput("rst_valid", 32'(oValid), 32'h0);
        checkOutput("rst_count", 32'(oCount), 32'h0);
        checkOutput("rst_empty", 32'(oEmpty), 32'h1);
        checkOutput("rst_full",  32'(oFull),  32'h0);
        checkOutput("rst_ovf",   32'(oOvf),   32'h0);
        checkOutput("rst_udf",   32'(oUdf),   32'h0);
        iRst = 1'b0;

        // Four writes, then four reads with one-cycle latency.
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h11 + k), 1'b0, 1'b0);
        checkOutput("t1_count4", 32'(oCount), 32'd4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("t1_valid", 32'(oValid), 32'h1);
            checkOutput("t1_data",  32'(oData),  32'h11 + 32'(k));
            checkOutput("t1_count", 32'(oCount), 32'd3 - 32'(k));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_valid_off", 32'(oValid), 32'h0);
        checkOutput("t1_empty",     32'(oEmpty), 32'h1);
        checkOutput("t1_data_hold", 32'(oData),  32'h14);

        // Read on empty is refused.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t4_valid", 32'(oValid), 32'h0);
        checkOutput("t4_data",  32'(oData),  32'h14);
        checkOutput("t4_count", 32'(oCount), 32'h0);
        checkOutput("t4_udf",   32'(oUdf),   32'(ERR));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t4_udf_clr", 32'(oUdf), 32'h0);

        // Incremental fill to full, watching the level flags.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_aempty0", 32'(oAEmpty), 32'h1);
        checkOutput("t5_afull0",  32'(oAFull),  32'h0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("t5_count",  32'(oCount),  32'(i + 1));
            checkOutput("t5_aempty", 32'(oAEmpty), 32'((i + 1) <= 8));
            checkOutput("t5_afull",  32'(oAFull),  32'((i + 1) >= 48));
        end
        checkOutput("t2_full", 32'(oFull), 32'h1);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("t2_count_drop", 32'(oCount), 32'd64);
        checkOutput("t2_full_hold",  32'(oFull),  32'h1);
        checkOutput("t2_ovf",        32'(oOvf),   32'(ERR));

        // Write and read together at full.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'(64 + k), 1'b1, 1'b0);
            checkOutput("t3_valid", 32'(oValid), 32'h1);
            checkOutput("t3_data",  32'(oData),  32'(k));
            checkOutput("t3_count", 32'(oCount), 32'd64);
            checkOutput("t3_full",  32'(oFull),  32'h1);
        end
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("t3_drain", 32'(oData), 32'(10 + k));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t3_empty", 32'(oEmpty), 32'h1);

        // Flush beats simultaneous write and read.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        checkOutput("t6_count20", 32'(oCount), 32'd20);
        checkOutput("t6_ovf_pre", 32'(oOvf),   32'(ERR));
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("t6_count", 32'(oCount), 32'h0);
        checkOutput("t6_empty", 32'(oEmpty), 32'h1);
        checkOutput("t6_valid", 32'(oValid), 32'h0);
        checkOutput("t6_ovf",   32'(oOvf),   32'h0);
        checkOutput("t6_udf",   32'(oUdf),   32'h0);
        checkOutput("t6_hold",  32'(oData),  32'd73);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t6_a5",       32'(oData),  32'hA5);
        checkOutput("t6_a5_valid", 32'(oValid), 32'h1);

        // Asynchronous reset between clock edges.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h5B, 1'b1, 1'b0);
        checkOutput("rst2_pre_valid", 32'(oValid), 32'h1);
        checkOutput("rst2_pre_data",  32'(oData),  32'h5A);
        iW_EN = 1'b0;
        iR_EN = 1'b0;
        #2;
        iRst = 1'b1;
        #1;
        checkOutput("rst2_valid", 32'(oValid), 32'h0);
        checkOutput("rst2_data",  32'(oData),  32'h0);
        checkOutput("rst2_count", 32'(oCount), 32'h0);
        checkOutput("rst2_empty", 32'(oEmpty), 32'h1);
        #1;
        iRst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
